clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Front-panel controller for the h/mi/s clock datapath. Converts three raw push-buttons (mode, up, down) into the time datapath's control strobes: enable_pulse_1s, enable_cnt_h/mi/s and single-cycle increase/decrease pulses.
- RUN: time runs normally.
- Three SET states: time is frozen and only the selected field is adjusted.
- Includes button synchronisation, edge detection, hold-to-auto-repeat, display blink and an idle timeout back to RUN.

Parameters:
HOLD_CYCLES, 50_000_000, cycles a button must be held after its first pulse before auto-repeat begins.
REPEAT_CYCLES, 10_000_000, cycles between auto-repeat pulses.
BLINK_CYCLES, 25_000_000, half-period of the blink toggle in SET states.
TIMEOUT_CYCLES, 500_000_000, idle cycles in a SET state before forced return to RUN.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_up  input  1  raw up button, asynchronous, active-high
btn_down  input  1  raw down button, asynchronous, active-high
mode  output  2  current state: 0=RUN, 1=SET_H, 2=SET_MI, 3=SET_S
enable_pulse_1s  output  1  1-second pulse generator enable
enable_cnt_h  output  1  hour counter enable
enable_cnt_mi  output  1  minute counter enable
enable_cnt_s  output  1  second counter enable
increase_h, decrease_h  output  1 each  hour adjust pulses
increase_mi, decrease_mi  output  1 each  minute adjust pulses
increase_s, decrease_s  output  1 each  second adjust pulses
blink  output  1  display-visibility flag for the selected field

Behaviour:
- Reset (async, any time, including mid-repeat or mid-SET):
  - mode=RUN.
  - All enables and all increase/decrease outputs = 0.
  - blink=1.
  - All sync, hold, repeat, blink and timeout counters cleared.
- All outputs are registered.
- From the first clk edge after rst falls, outputs take RUN values:
  - enable_pulse_1s=1.
  - enable_cnt_h/mi/s=1.
- Button conditioning:
  - 2-flop synchroniser per button, then rising-edge detect.
  - Latency: an adjust pulse is high for exactly one cycle, starting at the 3rd rising clk edge after the raw input goes high.
- FSM advances on a mode edge only: RUN -> SET_H -> SET_MI -> SET_S -> RUN.
- Outputs in SET_x:
  - enable_pulse_1s=0.
  - Only enable_cnt_x=1; the other two counters are disabled, so carry pulses from the adjusted field do not propagate.
- Adjust:
  - In SET_x, an up edge gives increase_x=1 for one cycle; a down edge gives decrease_x=1 for one cycle.
  - In RUN, up/down are ignored entirely.
- Auto-repeat:
  - While up (or down) stays held, a further pulse fires HOLD_CYCLES after the initial pulse.
  - Pulses then repeat every REPEAT_CYCLES.
  - Release clears the hold counter.
  - Mode has no auto-repeat.
- Simultaneous events:
  - Up and down edges in the same cycle: both ignored.
  - Up and down both held: repeat suppressed.
  - Mode edge coinciding with an up/down pulse: mode wins, adjust pulse dropped, hold counters cleared.
- Blink:
  - blink=1 in RUN.
  - Reloads to 1 on every state entry.
  - In SET, toggles every BLINK_CYCLES.
  - Forced to 1 for BLINK_CYCLES after any adjust pulse.
- Timeout:
  - In SET states, the idle counter increments each cycle and clears on any accepted edge or repeat pulse.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RUN on the next edge.
  - The counter is held at 0 in RUN.
- At most one increase/decrease output is high in any cycle.
- Counter widths use $clog2 of the corresponding parameter plus 1.

Decomposition:
- Package clock_pkg:
  - Mode enum (RUN/SET_H/SET_MI/SET_S, 2 bits).
  - Default timing constants for a 50 MHz clk.
- Sub-module btn_conditioner:
  - Synchroniser, edge detect and hold/repeat counter.
  - Parameters HOLD_CYCLES, REPEAT_CYCLES, REPEAT_EN.
  - Instantiated 3x; REPEAT_EN=0 for mode.
- The FSM, enable decode, blink and timeout logic live in clock_set_ctrl.

Test Plan:
Use small parameters: HOLD=8, REPEAT=4, BLINK=4, TIMEOUT=64.
1. Reset and RUN: rst pulse -> mode=0, blink=1; after release, enable_pulse_1s=1 and enable_cnt_h/mi/s=1; up pulses in RUN produce no increase_*.
2. Mode cycling: 4 mode presses -> mode steps 1,2,3,0. In mode=2, enable_cnt_mi=1, enable_cnt_h=0, enable_cnt_s=0, enable_pulse_1s=0.
3. Single adjust in SET_H: up held 2 cycles -> increase_h high for exactly 1 cycle at the 3rd edge after press. Down press -> decrease_h for 1 cycle.
4. Auto-repeat in SET_S: up held 30 cycles -> increase_s pulses at t0, t0+8, t0+12, t0+16, t0+20, t0+24, t0+28 (7 pulses). Release stops pulses.
5. Conflicts: up and down pressed in the same cycle -> no pulse. Mode and up edges coincident -> mode advances, no increase pulse.
6. Timeout and async reset: enter SET_MI, idle 64 cycles -> mode=0. Re-enter SET_H, hold up, assert rst mid-repeat -> immediate mode=0 and all pulses 0; no pulse after release until a fresh press.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock front-panel controller.
// Defaults assume a 50 MHz system clock.
package clock_pkg;

    typedef enum logic [1:0] {
        ModeRun   = 2'd0,
        ModeSetH  = 2'd1,
        ModeSetMi = 2'd2,
        ModeSetS  = 2'd3
    } mode_e;

    localparam int unsigned DefHoldCycles    = 50_000_000;
    localparam int unsigned DefRepeatCycles  = 10_000_000;
    localparam int unsigned DefBlinkCycles   = 25_000_000;
    localparam int unsigned DefTimeoutCycles = 500_000_000;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        unique case (m)
            ModeRun:   n = ModeSetH;
            ModeSetH:  n = ModeSetMi;
            ModeSetMi: n = ModeSetS;
            default:   n = ModeRun;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchroniser, rising-edge detect and
// hold-to-auto-repeat timer (repeat disabled when REPEAT_EN is 0).
module btn_conditioner
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
    parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic rpt_o
);
    localparam int unsigned MaxCycles =
        (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] HoldCnt = CntW'(HOLD_CYCLES);
    localparam logic [CntW-1:0] RepCnt  = CntW'(REPEAT_CYCLES);

    logic            sync1_q, sync2_q, prev_q;
    logic            armed_q, armed_d;
    logic            rep_phase_q, rep_phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;

    // cnt_q equals the number of cycles since the last pulse while armed.
    always_comb begin
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        rep_phase_d = rep_phase_q;
        rpt_o       = 1'b0;
        if (!REPEAT_EN || clr_i || !sync2_q) begin
            cnt_d       = '0;
            armed_d     = 1'b0;
            rep_phase_d = 1'b0;
        end else if (rise_o) begin
            cnt_d       = CntW'(1);
            armed_d     = 1'b1;
            rep_phase_d = 1'b0;
        end else if (armed_q) begin
            if (cnt_q == (rep_phase_q ? RepCnt : HoldCnt)) begin
                rpt_o       = 1'b1;
                cnt_d       = CntW'(1);
                rep_phase_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            armed_q     <= 1'b0;
            rep_phase_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            armed_q     <= armed_d;
            rep_phase_q <= rep_phase_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller: mode FSM (RUN / SET_H / SET_MI / SET_S), counter enables,
// adjust pulses, display blink and idle timeout back to RUN. All outputs registered.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = DefHoldCycles,
    parameter int unsigned REPEAT_CYCLES  = DefRepeatCycles,
    parameter int unsigned BLINK_CYCLES   = DefBlinkCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic       enable_pulse_1s,
    output logic       enable_cnt_h,
    output logic       enable_cnt_mi,
    output logic       enable_cnt_s,
    output logic       increase_h,
    output logic       decrease_h,
    output logic       increase_mi,
    output logic       decrease_mi,
    output logic       increase_s,
    output logic       decrease_s,
    output logic       blink
);
    localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES) + 1;
    localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TIMEOUT_CYCLES);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

    logic mode_rise, unused_mode_lvl, unused_mode_rpt;
    logic up_rise, up_lvl, up_rpt;
    logic dn_rise, dn_lvl, dn_rpt;
    logic up_ev, dn_ev, adj_up, adj_dn, adj_any;

    mode_e             mode_q, mode_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] bcnt_q, bcnt_d;
    logic              blink_q, blink_d;
    logic [3:0]        en_q, en_d;   // {pulse_1s, h, mi, s}
    logic [5:0]        adj_q, adj_d; // {dec_s, inc_s, dec_mi, inc_mi, dec_h, inc_h}

    btn_conditioner #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b0)
    ) u_mode (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_mode),
        .clr_i  (1'b0),
        .level_o(unused_mode_lvl),
        .rise_o (mode_rise),
        .rpt_o  (unused_mode_rpt)
    );

    btn_conditioner #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_up (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_up),
        .clr_i  (mode_rise),
        .level_o(up_lvl),
        .rise_o (up_rise),
        .rpt_o  (up_rpt)
    );

    btn_conditioner #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_down (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_down),
        .clr_i  (mode_rise),
        .level_o(dn_lvl),
        .rise_o (dn_rise),
        .rpt_o  (dn_rpt)
    );

    always_comb begin
        // Repeats need the opposite button released; a mode edge overrides any adjust.
        up_ev   = up_rise | (up_rpt & ~dn_lvl);
        dn_ev   = dn_rise | (dn_rpt & ~up_lvl);
        adj_up  = up_ev & ~dn_ev & ~mode_rise & (mode_q != ModeRun);
        adj_dn  = dn_ev & ~up_ev & ~mode_rise & (mode_q != ModeRun);
        adj_any = adj_up | adj_dn;

        mode_d = mode_q;
        idle_d = idle_q;
        if (mode_rise) begin
            mode_d = next_mode(mode_q);
            idle_d = '0;
        end else if (mode_q == ModeRun || adj_any) begin
            idle_d = '0;
        end else if (idle_q == IdleLast) begin
            mode_d = ModeRun;
            idle_d = '0;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end

        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (mode_d != mode_q || adj_any || mode_d == ModeRun) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BlinkLast) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + BlinkW'(1);
        end

        unique case (mode_d)
            ModeRun:   en_d = 4'b1111;
            ModeSetH:  en_d = 4'b0100;
            ModeSetMi: en_d = 4'b0010;
            default:   en_d = 4'b0001;
        endcase

        unique case (mode_q)
            ModeSetH:  adj_d = {4'b0000, adj_dn, adj_up};
            ModeSetMi: adj_d = {2'b00, adj_dn, adj_up, 2'b00};
            ModeSetS:  adj_d = {adj_dn, adj_up, 4'b0000};
            default:   adj_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= ModeRun;
            idle_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b1;
            en_q    <= 4'b0000;
            adj_q   <= 6'b000000;
        end else begin
            mode_q  <= mode_d;
            idle_q  <= idle_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            en_q    <= en_d;
            adj_q   <= adj_d;
        end
    end

    assign mode            = mode_q;
    assign blink           = blink_q;
    assign enable_pulse_1s = en_q[3];
    assign enable_cnt_h    = en_q[2];
    assign enable_cnt_mi   = en_q[1];
    assign enable_cnt_s    = en_q[0];
    assign increase_h      = adj_q[0];
    assign decrease_h      = adj_q[1];
    assign increase_mi     = adj_q[2];
    assign decrease_mi     = adj_q[3];
    assign increase_s      = adj_q[4];
    assign decrease_s      = adj_q[5];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed-plus-random bench for clock_set_ctrl using small timing parameters and a
// cycle-count reference model of mode, enables, adjust pulses, blink and timeout.
module tb_clock_set_ctrl;
    localparam int Hold = 8;
    localparam int Rep  = 4;
    localparam int Blnk = 4;
    localparam int Tmo  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [1:0] mode;
    logic       enable_pulse_1s, enable_cnt_h, enable_cnt_mi, enable_cnt_s;
    logic       increase_h, decrease_h, increase_mi, decrease_mi, increase_s, decrease_s;
    logic       blink;

    int total = 0, bad = 0;
    int cyc = 0, exp_mode = 0, last_act = 0, reload = 0, pulses = 0;
    bit exp_step = 1'b0, exp_up = 1'b0, exp_dn = 1'b0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .HOLD_CYCLES   (Hold),
        .REPEAT_CYCLES (Rep),
        .BLINK_CYCLES  (Blnk),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_mode       (btn_mode),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .mode           (mode),
        .enable_pulse_1s(enable_pulse_1s),
        .enable_cnt_h   (enable_cnt_h),
        .enable_cnt_mi  (enable_cnt_mi),
        .enable_cnt_s   (enable_cnt_s),
        .increase_h     (increase_h),
        .decrease_h     (decrease_h),
        .increase_mi    (increase_mi),
        .decrease_mi    (decrease_mi),
        .increase_s     (increase_s),
        .decrease_s     (decrease_s),
        .blink          (blink)
    );

    function automatic logic [5:0] obs_adj();
        return {decrease_s, increase_s, decrease_mi, increase_mi, decrease_h, increase_h};
    endfunction

    function automatic logic [3:0] obs_en();
        return {enable_pulse_1s, enable_cnt_h, enable_cnt_mi, enable_cnt_s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"}, 32'(mode), 0);
        chk({tag, "_en"}, 32'(obs_en()), 0);
        chk({tag, "_adj"}, 32'(obs_adj()), 0);
        chk({tag, "_blink"}, 32'(blink), 1);
    endtask

    // p cycles after the first accepted pulse of a press whose level lasts n cycles.
    function automatic bit pulse_at(input int p, input int n);
        if (p < 0 || p > n - 1) return 1'b0;
        return (p == 0) || (p >= Hold && (p - Hold) % Rep == 0);
    endfunction

    // One clock: advance the model by the caller's expectations, then compare everything.
    task automatic tick();
        int         pre;
        logic [5:0] ea;
        logic [3:0] een;
        logic       eb;
        @(posedge clk);
        #1;
        cyc++;
        pre = exp_mode;
        ea  = '0;
        if (exp_step) begin
            exp_mode = (exp_mode + 1) % 4;
            last_act = cyc;
            reload   = cyc;
        end else if (pre != 0 && (exp_up || exp_dn)) begin
            ea[2*(pre-1)]   = exp_up;
            ea[2*(pre-1)+1] = exp_dn;
            last_act = cyc;
            reload   = cyc;
        end else if (pre != 0 && cyc - last_act == Tmo + 1) begin
            exp_mode = 0;
        end
        een = 4'b1000;
        een = (exp_mode == 0) ? 4'b1111 : (een >> exp_mode);
        eb  = (exp_mode == 0) || (((cyc - reload) / Blnk) % 2 == 0);
        if (obs_adj() != 6'd0) pulses++;
        chk("mode", 32'(mode), 32'(exp_mode));
        chk("enables", 32'(obs_en()), 32'(een));
        chk("adjust", 32'(obs_adj()), 32'(ea));
        chk("blink", 32'(blink), 32'(eb));
    endtask

    task automatic idle(input int n);
        exp_step = 1'b0;
        exp_up   = 1'b0;
        exp_dn   = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press(input bit m, input bit u, input bit d, input int n, input int tail);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        for (int k = 1; k <= n + tail; k++) begin
            exp_step = m && (k == 3);
            exp_up   = u && !d && !m && pulse_at(k - 3, n);
            exp_dn   = d && !u && !m && pulse_at(k - 3, n);
            tick();
            if (k == n) begin
                btn_mode = 1'b0;
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
        end
        exp_step = 1'b0;
        exp_up   = 1'b0;
        exp_dn   = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int r;
        // Reset and RUN
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        idle(3);
        press(0, 1, 0, 12, 4);
        press(0, 0, 1, 3, 3);

        // Mode cycling
        press(1, 0, 0, 2, 3);
        press(1, 0, 0, 2, 3);
        chk("mi_enables", 32'(obs_en()), 32'h2);
        press(1, 0, 0, 2, 3);
        press(1, 0, 0, 2, 3);
        chk("back_to_run", 32'(mode), 0);

        // Single adjust in SET_H
        press(1, 0, 0, 1, 3);
        press(0, 1, 0, 2, 3);
        press(0, 0, 1, 1, 3);

        // Auto-repeat in SET_S
        press(1, 0, 0, 1, 3);
        press(1, 0, 0, 1, 3);
        pulses = 0;
        press(0, 1, 0, 30, 4);
        chk("repeat_count", 32'(pulses), 7);

        // Conflicts
        press(0, 1, 1, 12, 4);
        press(1, 0, 0, 2, 3);
        press(1, 0, 0, 2, 3);
        pulses = 0;
        press(1, 1, 0, 15, 4);
        chk("mode_wins_pulses", 32'(pulses), 0);
        chk("mode_wins_mode", 32'(mode), 2);

        // Timeout from SET_MI
        idle(70);
        chk("timeout", 32'(mode), 0);

        // Async reset mid-repeat in SET_H
        press(1, 0, 0, 1, 3);
        btn_up = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            exp_up = pulse_at(k - 3, 100);
            tick();
        end
        exp_up = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_reset("rst_held");
        btn_up = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_mode = 0;
        pulses   = 0;
        idle(10);
        chk("no_pulse_after_rst", 32'(pulses), 0);
        press(1, 0, 0, 1, 3);
        press(0, 1, 0, 2, 3);

        // Random mix
        for (int it = 0; it < 25; it++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: press(1, 0, 0, int'($urandom_range(1, 3)), int'($urandom_range(3, 6)));
                1: press(0, 1, 0, int'($urandom_range(1, 30)), int'($urandom_range(3, 6)));
                2: press(0, 0, 1, int'($urandom_range(1, 30)), int'($urandom_range(3, 6)));
                3: press(0, 1, 1, int'($urandom_range(1, 20)), int'($urandom_range(3, 6)));
                default: idle(int'($urandom_range(1, 30)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
